// File: rtl/poly_eval_responder.sv
// Multi-cycle evaluator of f(x) = A*x^2 + B*x + C, f'(x) and a learning-rate step, sharing one 32x32 multiplier.
// Optional build macro POLY_EVAL_SAT_EN: overflowing results saturate instead of wrapping.
module poly_eval_responder #(
  parameter logic signed [31:0] COEF_A        = 32'h00000100,
  parameter logic signed [31:0] COEF_B        = 32'hFFFFFC00,
  parameter logic signed [31:0] COEF_C        = 32'h00000300,
  parameter logic signed [31:0] LEARNING_RATE = 32'h00000080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_func,
  input  logic [31:0] x_in,
  output logic [63:0] value,
  output logic [31:0] gradient,
  output logic [31:0] x_diff_out,
  output logic        func_done,
  output logic        overflow
);

  typedef enum logic [2:0] {IDLE, MUL1, MUL2, MUL3, DONE} state_t;

  state_t             state;
  logic signed [31:0] x_q;
  logic signed [31:0] p1_q;
  logic               p1_ovf_q;

  logic signed [31:0] mul_a;
  logic signed [31:0] mul_b;
  logic signed [63:0] mul_p;
  logic signed [63:0] mul_shr;
  logic               mul_shr_ovf;
  logic [32:0]        s_sum;
  logic               s_ovf;
  logic [33:0]        grad_sum;
  logic               grad_ovf;
  logic [64:0]        val_sum;
  logic               val_ovf;
  logic [63:0]        value_nxt;
  logic [31:0]        gradient_nxt;
  logic [31:0]        x_diff_nxt;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    mul_a = COEF_A;
    mul_b = x_q;
    case (state)
      MUL2: begin
        mul_a = x_q;
        mul_b = s_sum[31:0];
      end
      MUL3: begin
        mul_a = LEARNING_RATE;
        mul_b = gradient;
      end
      default: ;
    endcase
  end

  assign mul_p       = 64'(mul_a) * 64'(mul_b);
  assign mul_shr     = mul_p >>> 8;
  assign mul_shr_ovf = !((&mul_shr[63:31]) || !(|mul_shr[63:31]));

  // Sums are one or two bits wider than their results so the sign of the true value is always visible.
  assign s_sum    = {p1_q[31], p1_q} + {COEF_B[31], COEF_B};
  assign s_ovf    = s_sum[32] ^ s_sum[31];
  assign grad_sum = {p1_q[31], p1_q, 1'b0} + {{2{COEF_B[31]}}, COEF_B};
  assign grad_ovf = !((&grad_sum[33:31]) || !(|grad_sum[33:31]));
  assign val_sum  = {mul_p[63], mul_p} + {{25{COEF_C[31]}}, COEF_C, 8'h00};
  assign val_ovf  = val_sum[64] ^ val_sum[63];

`ifdef POLY_EVAL_SAT_EN
  function automatic logic [31:0] sat32(input logic neg);
    return neg ? 32'h80000000 : 32'h7FFFFFFF;
  endfunction

  function automatic logic [63:0] sat64(input logic neg);
    return neg ? 64'h8000000000000000 : 64'h7FFFFFFFFFFFFFFF;
  endfunction

  assign value_nxt    = val_ovf     ? sat64(val_sum[64])  : val_sum[63:0];
  assign gradient_nxt = grad_ovf    ? sat32(grad_sum[33]) : grad_sum[31:0];
  assign x_diff_nxt   = mul_shr_ovf ? sat32(mul_shr[63])  : mul_shr[31:0];
`else
  assign value_nxt    = val_sum[63:0];
  assign gradient_nxt = grad_sum[31:0];
  assign x_diff_nxt   = mul_shr[31:0];
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: everything, including the captured operand, is cleared; there is no memory array to exempt.
      state      <= IDLE;
      x_q        <= '0;
      p1_q       <= '0;
      p1_ovf_q   <= 1'b0;
      value      <= '0;
      gradient   <= '0;
      x_diff_out <= '0;
      func_done  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_func) begin
            x_q      <= x_in;
            overflow <= 1'b0;
            state    <= MUL1;
          end
        end
        MUL1: begin
          if (!start_func) begin
            state <= IDLE;
          end else begin
            p1_q     <= mul_shr[31:0];
            p1_ovf_q <= mul_shr_ovf;
            state    <= MUL2;
          end
        end
        MUL2: begin
          if (!start_func) begin
            state <= IDLE;
          end else begin
            value    <= value_nxt;
            gradient <= gradient_nxt;
            overflow <= overflow | p1_ovf_q | s_ovf | grad_ovf | val_ovf;
            state    <= MUL3;
          end
        end
        MUL3: begin
          if (!start_func) begin
            state <= IDLE;
          end else begin
            x_diff_out <= x_diff_nxt;
            overflow   <= overflow | mul_shr_ovf;
            func_done  <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (!start_func) begin
            func_done <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_eval_responder.sv
// Scoreboard bench for poly_eval_responder: expected results are queued at capture and checked at func_done.
module tb_poly_eval_responder;

  localparam logic signed [31:0] A  = 32'h00000100;
  localparam logic signed [31:0] B  = 32'hFFFFFC00;
  localparam logic signed [31:0] C  = 32'h00000300;
  localparam logic signed [31:0] LR = 32'h00000080;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_func;
  logic [31:0] x_in;
  logic [63:0] value;
  logic [31:0] gradient;
  logic [31:0] x_diff_out;
  logic        func_done;
  logic        overflow;

  always #5 clk = ~clk;

  poly_eval_responder #(
    .COEF_A(A), .COEF_B(B), .COEF_C(C), .LEARNING_RATE(LR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_func(start_func),
    .x_in(x_in),
    .value(value),
    .gradient(gradient),
    .x_diff_out(x_diff_out),
    .func_done(func_done),
    .overflow(overflow)
  );

  typedef struct {
    logic [63:0] value;
    logic [31:0] grad;
    logic [31:0] xd;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model in wide signed arithmetic.
  function automatic logic in_range(input logic signed [127:0] t, input int bits);
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    hi = (128'sd1 <<< (bits - 1)) - 128'sd1;
    lo = -hi - 128'sd1;
    return (t <= hi) && (t >= lo);
  endfunction

  function automatic exp_t model(input logic signed [31:0] x);
    logic signed [127:0] xw, t;
    logic signed [31:0]  p1, s, g;
    logic                ok;
    exp_t                e;
    xw    = x;
    e.ovf = 1'b0;
    t = A;
    t = (t * xw) >>> 8;
    e.ovf |= !in_range(t, 32);
    p1 = t[31:0];
    t = p1;
    t = t + B;
    e.ovf |= !in_range(t, 32);
    s = t[31:0];
    t = s;
    t = xw * t + C * 256;
    ok = in_range(t, 64);
    e.ovf |= !ok;
`ifdef POLY_EVAL_SAT_EN
    e.value = ok ? t[63:0] : ((t < 0) ? 64'h8000000000000000 : 64'h7FFFFFFFFFFFFFFF);
`else
    e.value = t[63:0];
`endif
    t = p1;
    t = 2 * t + B;
    ok = in_range(t, 32);
    e.ovf |= !ok;
`ifdef POLY_EVAL_SAT_EN
    g = ok ? t[31:0] : ((t < 0) ? 32'h80000000 : 32'h7FFFFFFF);
`else
    g = t[31:0];
`endif
    e.grad = g;
    t = g;
    t = (t * LR) >>> 8;
    ok = in_range(t, 32);
    e.ovf |= !ok;
`ifdef POLY_EVAL_SAT_EN
    e.xd = ok ? t[31:0] : ((t < 0) ? 32'h80000000 : 32'h7FFFFFFF);
`else
    e.xd = t[31:0];
`endif
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_outputs(input string tag, input exp_t e, input logic done);
    check({tag, ".done"},     64'(func_done),  64'(done));
    check({tag, ".value"},    value,           e.value);
    check({tag, ".gradient"}, 64'(gradient),   64'(e.grad));
    check({tag, ".x_diff"},   64'(x_diff_out), 64'(e.xd));
    check({tag, ".overflow"}, 64'(overflow),   64'(e.ovf));
  endtask

  // Drive a capture, scramble x_in afterwards, wait (bounded) for done, then pop and compare.
  task automatic run_txn(input string tag, input logic [31:0] x, input exp_t e, output int n);
    exp_t exp_e;
    x_in       = x;
    start_func = 1'b1;
    sb.push_back(e);
    tick();
    x_in = $urandom();
    n = 1;
    while (!func_done && n < 20) begin
      tick();
      n++;
    end
    check({tag, ".latency"}, 64'(n), 64'd4);
    exp_e = sb.pop_front();
    check_outputs(tag, exp_e, 1'b1);
    last = exp_e;
  endtask

  task automatic drop(input string tag);
    start_func = 1'b0;
    tick();
    check({tag, ".drop"}, 64'(func_done), 64'd0);
  endtask

  exp_t              zero_e;
  exp_t              m;
  exp_t              e1;
  int                n;
  int                n2;
  logic [31:0]       xs[4];

  initial begin
    zero_e = '{value: 64'h0, grad: 32'h0, xd: 32'h0, ovf: 1'b0};
    rst = 1'b1;
    start_func = 1'b0;
    x_in = '0;
    tick();
    tick();
    check_outputs("reset", zero_e, 1'b0);
    rst = 1'b0;

    // x = 1.0: minimum of nothing, root of f
    e1 = '{value: 64'h0, grad: 32'hFFFFFE00, xd: 32'hFFFFFF00, ovf: 1'b0};
    run_txn("x1", 32'h00000100, e1, n);
    drop("x1");

    // x = 2.0: the minimum, zero gradient
    run_txn("x2", 32'h00000200,
            '{value: 64'hFFFFFFFFFFFF0000, grad: 32'h0, xd: 32'h0, ovf: 1'b0}, n);
    drop("x2");

    // x = 0: result held for 10 cycles while start stays high and x_in wanders
    run_txn("x0", 32'h00000000,
            '{value: 64'h30000, grad: 32'hFFFFFC00, xd: 32'hFFFFFE00, ovf: 1'b0}, n);
    for (int i = 0; i < 10; i++) begin
      x_in = $urandom();
      tick();
      check_outputs("hold", last, 1'b1);
    end
    drop("x0");

    // back-to-back: one extra hold edge, one low edge, then a new capture
    run_txn("b2b1", 32'h00000200, model(32'h00000200), n);
    tick();
    check("b2b.hold", 64'(func_done), 64'd1);
    start_func = 1'b0;
    tick();
    check("b2b.low", 64'(func_done), 64'd0);
    run_txn("b2b2", 32'h00000100, e1, n2);
    check("b2b.edges", 64'(2 + n2), 64'd6);
    drop("b2b2");

    // abort in MUL2: nothing changes
    x_in = 32'h00000300;
    start_func = 1'b1;
    tick();
    tick();
    start_func = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check_outputs("abort2", last, 1'b0);
    end

    // abort in MUL3: value/gradient already updated, x_diff_out keeps the old step
    m = model(32'h00000300);
    x_in = 32'h00000300;
    start_func = 1'b1;
    tick();
    tick();
    tick();
    start_func = 1'b0;
    tick();
    tick();
    check_outputs("abort3", '{value: m.value, grad: m.grad, xd: last.xd, ovf: 1'b0}, 1'b0);

    // reset mid-computation, then reset with start high in IDLE must not capture
    x_in = 32'h00000200;
    start_func = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    check_outputs("rst_mul1", zero_e, 1'b0);
    tick();
    check("rst_prio.done", 64'(func_done), 64'd0);
    rst = 1'b0;
    run_txn("after_rst", 32'h00000100, e1, n);
    drop("after_rst");

    // large positive x overflows the gradient
    run_txn("ovf", 32'h7FFFFF00, model(32'h7FFFFF00), n);
`ifdef POLY_EVAL_SAT_EN
    check("ovf.grad_const", 64'(gradient), 64'h7FFFFFFF);
`else
    check("ovf.grad_const", 64'(gradient), 64'hFFFFFA00);
`endif
    check("ovf.flag_const", 64'(overflow), 64'd1);
    drop("ovf");

    // overflow flag clears on the next capture
    run_txn("ovf_clr", 32'h00000100, e1, n);
    drop("ovf_clr");

    xs = '{32'h80000000, 32'hFFFFF800, 32'h00012345, 32'hFFFF0080};
    for (int i = 0; i < 8; i++) begin
      logic [31:0] x;
      x = (i < 4) ? xs[i] : ((i < 6) ? ($urandom() >>> 12) : $urandom());
      run_txn($sformatf("rnd%0d", i), x, model(x), n);
      drop($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/poly_eval_responder.md
POLY_EVAL_RESPONDER -- requirements
Module: poly_eval_responder

Interface
REQ-001 Parameter COEF_A, default 32'h00000100, quadratic coefficient A, signed Q24.8.
REQ-002 Parameter COEF_B, default 32'hFFFFFC00, linear coefficient B, signed Q24.8.
REQ-003 Parameter COEF_C, default 32'h00000300, constant C, signed Q24.8.
REQ-004 Parameter LEARNING_RATE, default 32'h00000080, step scale, signed Q24.8.
REQ-005 Ports, clock and reset first; one clock; reset is synchronous and active-high:
- clk  input  1  sole clock, all state changes on rising edge.
- rst  input  1  synchronous active-high reset.
- start_func  input  1  level request from the optimizer driver.
- x_in  input  32  signed Q24.8 evaluation point.
- value  output  64  signed Q48.16 f(x) = A*x^2 + B*x + C.
- gradient  output  32  signed Q24.8 f'(x) = 2*A*x + B.
- x_diff_out  output  32  signed Q24.8 step = LEARNING_RATE*gradient.
- func_done  output  1  results valid, level.
- overflow  output  1  arithmetic overflow in current result set.

Function
REQ-006 FSM states IDLE, MUL1, MUL2, MUL3, DONE; exactly one signed 32x32->64 multiplier, shared across MUL1-MUL3.
REQ-007 IDLE: start_func=1 at a rising edge -> capture x_in into internal x_q, clear overflow, go MUL1; x_in changes afterwards are ignored.
REQ-008 MUL1: p1 = (COEF_A*x_q)>>>8, truncated to 32 bits; go MUL2.
REQ-009 MUL2: s = p1+COEF_B (32 bits); value = x_q*s + (sign-extended COEF_C <<< 8); gradient = (p1<<<1)+COEF_B; go MUL3.
REQ-010 MUL3: x_diff_out = (LEARNING_RATE*gradient)>>>8, truncated to 32 bits; go DONE with func_done=1.
REQ-011 Latency: func_done is first high after the 4th rising edge, counting the capture edge as edge 1.
REQ-012 DONE: func_done, value, gradient, x_diff_out, overflow held stable while start_func=1.
REQ-013 DONE with start_func=0 at a rising edge -> func_done=0, go IDLE; a new capture needs start_func=1 at a later edge in IDLE (four-phase handshake; a one-cycle low pulse is sufficient).
REQ-014 start_func=0 at any edge in MUL1-MUL3 -> abort to IDLE; func_done stays 0; outputs retain previous values.
REQ-015 overflow is set (sticky until next capture) if any of the following is outside signed range: p1 truncation, s sum, gradient sum or shift, value sum, or x_diff_out truncation.
REQ-016 Outputs change only at the MUL2/MUL3 update edges or reset; never while func_done=1.

Reset
REQ-017 rst=1 at a rising edge, in any state (including mid-computation) -> state IDLE, value=0, gradient=0, x_diff_out=0, func_done=0, overflow=0, x_q=0.
REQ-018 rst has priority over start_func at the same edge; no capture happens on a reset edge.

Configuration
REQ-019 Macro POLY_EVAL_SAT_EN defined: on overflow, gradient and x_diff_out saturate to 32'h7FFFFFFF / 32'h80000000 by sign of the true result, and value saturates to 64'h7FFFFFFFFFFFFFFF / 64'h8000000000000000.
REQ-020 POLY_EVAL_SAT_EN undefined: overflowing results wrap (two's complement truncation); overflow flag behaviour is identical in both builds.

Verification (default parameters: f = x^2 - 4x + 3)
REQ-021 x_in=32'h00000100 (1.0), start held -> after 4 edges value=64'h0, gradient=32'hFFFFFE00, x_diff_out=32'hFFFFFF00, overflow=0.
REQ-022 x_in=32'h00000200 (2.0) -> value=64'hFFFFFFFFFFFF0000, gradient=0, x_diff_out=0; start dropped for 1 cycle -> func_done=0 next edge.
REQ-023 x_in=0 -> value=64'h30000, gradient=32'hFFFFFC00, x_diff_out=32'hFFFFFE00; func_done held while start_func=1 for 10 cycles.
REQ-024 Back-to-back: start high, done, start low 1 cycle, start high with x_in=32'h00000100 -> second result per REQ-021; total 6 edges after the first done.
REQ-025 Abort and reset: start_func low in MUL2 -> IDLE, func_done never rises; rst asserted in MUL1 -> all outputs 0 on next edge.
REQ-026 x_in=32'h7FFFFF00 -> overflow=1; gradient=32'h7FFFFFFF with POLY_EVAL_SAT_EN, wrapped value without.
